// File: rtl/packer_frame_arbiter.sv
// Round-robin frame arbiter in front of the dataPacker: one source owns the packer
// input from its first beat until its eof beat or until an idle timeout releases it.
module packer_frame_arbiter #(
   parameter int N          = 8,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REQ    = 4,
   parameter int MAX_IDLE   = 16
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              tracing,
   input  logic [NUM_REQ-1:0]                req_valid,
   input  logic [NUM_REQ-1:0]                req_eof,
   input  logic [NUM_REQ-1:0]                req_chainId,
   input  logic [NUM_REQ*N*DATA_WIDTH-1:0]   req_vector,
   output logic [NUM_REQ-1:0]                req_ready,
   output logic                              valid_out,
   output logic                              eof_out,
   output logic                              chainId_out,
   output logic [N-1:0][DATA_WIDTH-1:0]      vector_out,
   output logic [$clog2(NUM_REQ)-1:0]        grant_id,
   output logic                              busy,
   output logic                              timeout_pulse
);
   localparam int         GW         = $clog2(NUM_REQ);
   localparam int         VW         = N * DATA_WIDTH;
   localparam logic [7:0] IDLE_LIMIT = 8'(MAX_IDLE - 1);

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   state_t        state_r;
   logic [GW-1:0] rr_ptr_r;
   logic [7:0]    idle_cnt_r;
   logic [GW-1:0] winner_s;
   logic [GW-1:0] sel_s;
   logic          accept_s;
   logic [VW-1:0] sel_vec_s;

   function automatic logic [GW-1:0] rr_index(input logic [GW-1:0] base, input int k);
      int sum;
      sum = (int'(base) + k) % NUM_REQ;
      return GW'(sum);
   endfunction

   // Round-robin search after rr_ptr; walking the distance downwards lets the nearest valid requester win.
   always_comb begin
      winner_s = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         winner_s = req_valid[rr_index(rr_ptr_r, k)] ? rr_index(rr_ptr_r, k) : winner_s;
      end
   end

   // A locked frame keeps the port; when nobody is valid, winner_s points at an idle requester and nothing is accepted.
   assign sel_s     = (state_r == ST_LOCKED) ? grant_id : winner_s;
   assign accept_s  = tracing & req_valid[sel_s];
   assign sel_vec_s = req_vector[int'(sel_s) * VW +: VW];

   // One-hot ready towards the selected requester.
   always_comb begin
      req_ready        = '0;
      req_ready[sel_s] = accept_s;
   end

   // Arbitration state, frame lock, idle timeout and the registered forwarding stage.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r       <= ST_IDLE;
         rr_ptr_r      <= GW'(NUM_REQ - 1);
         idle_cnt_r    <= 8'd0;
         grant_id      <= '0;
         busy          <= 1'b0;
         timeout_pulse <= 1'b0;
         valid_out     <= 1'b0;
         eof_out       <= 1'b0;
         chainId_out   <= 1'b0;
         vector_out    <= '0;
      end else begin
         valid_out     <= accept_s;
         eof_out       <= accept_s & req_eof[sel_s];
         timeout_pulse <= 1'b0;
         if (accept_s) begin
            chainId_out <= req_chainId[sel_s];
            vector_out  <= sel_vec_s;
         end
         case (state_r)
            ST_IDLE: begin
               if (accept_s) begin
                  grant_id <= winner_s;
                  if (req_eof[winner_s]) begin
                     rr_ptr_r <= winner_s;
                  end else begin
                     state_r    <= ST_LOCKED;
                     busy       <= 1'b1;
                     idle_cnt_r <= 8'd0;
                  end
               end
            end
            ST_LOCKED: begin
               if (accept_s) begin
                  idle_cnt_r <= 8'd0;
                  if (req_eof[grant_id]) begin
                     state_r  <= ST_IDLE;
                     busy     <= 1'b0;
                     rr_ptr_r <= grant_id;
                  end
               end else if (tracing) begin
                  // The owner has been silent for MAX_IDLE traced cycles: drop the lock.
                  if (idle_cnt_r >= IDLE_LIMIT) begin
                     state_r       <= ST_IDLE;
                     busy          <= 1'b0;
                     rr_ptr_r      <= grant_id;
                     idle_cnt_r    <= 8'd0;
                     timeout_pulse <= 1'b1;
                  end else begin
                     idle_cnt_r <= (idle_cnt_r == 8'hFF) ? idle_cnt_r : idle_cnt_r + 8'd1;
                  end
               end
            end
            default: begin
               state_r <= ST_IDLE;
               busy    <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_packer_frame_arbiter.sv
// Directed and randomized bench for packer_frame_arbiter, checked each cycle against
// a frame-level reference model (owner / last releaser / silent-cycle count).
module tb_packer_frame_arbiter;
   localparam int N  = 8;
   localparam int DW = 32;
   localparam int NR = 4;
   localparam int MI = 16;
   localparam int GW = 2;
   localparam int VW = N * DW;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 tracing;
   logic [NR-1:0]        req_valid;
   logic [NR-1:0]        req_eof;
   logic [NR-1:0]        req_chainId;
   logic [NR*VW-1:0]     req_vector;
   logic [NR-1:0]        req_ready;
   logic                 valid_out;
   logic                 eof_out;
   logic                 chainId_out;
   logic [N-1:0][DW-1:0] vector_out;
   logic [GW-1:0]        grant_id;
   logic                 busy;
   logic                 timeout_pulse;

   int tests = 0;
   int fails = 0;

   // Reference model: open frame owner (-1 = none), last releasing requester, silent traced cycles.
   int          owner;
   int          last;
   int          quiet;
   int          m_gid;
   int          pulse_cnt;
   logic        m_valid, m_eof, m_chain, m_pulse;
   logic [VW-1:0] m_vec;

   packer_frame_arbiter #(.N(N), .DATA_WIDTH(DW), .NUM_REQ(NR), .MAX_IDLE(MI)) dut (
      .clk(clk), .rst_n(rst_n), .tracing(tracing),
      .req_valid(req_valid), .req_eof(req_eof), .req_chainId(req_chainId),
      .req_vector(req_vector), .req_ready(req_ready),
      .valid_out(valid_out), .eof_out(eof_out), .chainId_out(chainId_out),
      .vector_out(vector_out), .grant_id(grant_id), .busy(busy),
      .timeout_pulse(timeout_pulse)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int pick();
      for (int k = 1; k <= NR; k++) begin
         int r;
         r = (last + k) % NR;
         if (req_valid[r]) return r;
      end
      return -1;
   endfunction

   task automatic pattern_vectors();
      for (int r = 0; r < NR; r++)
         for (int i = 0; i < N; i++)
            req_vector[(r*N+i)*DW +: DW] = DW'(r*100 + i);
   endtask

   // One clock: check ready before the edge, advance the model, check outputs after the edge.
   task automatic step();
      int w;
      logic [NR-1:0] er;
      @(negedge clk);
      w = -1;
      if (tracing) begin
         if (owner < 0) w = pick();
         else if (req_valid[owner]) w = owner;
      end
      er = '0;
      if (w >= 0) er[w] = 1'b1;
      if (rst_n) chk("req_ready", VW'(req_ready), VW'(er));
      if (!rst_n) begin
         owner = -1; last = NR - 1; quiet = 0; m_gid = 0;
         m_valid = 1'b0; m_eof = 1'b0; m_chain = 1'b0; m_vec = '0; m_pulse = 1'b0;
      end else begin
         m_valid = (w >= 0);
         m_pulse = 1'b0;
         if (w >= 0) begin
            m_eof = req_eof[w]; m_chain = req_chainId[w]; m_vec = req_vector[w*VW +: VW];
         end
         if (owner < 0) begin
            if (w >= 0) begin
               m_gid = w;
               if (req_eof[w]) last = w;
               else begin owner = w; quiet = 0; end
            end
         end else if (w >= 0) begin
            quiet = 0;
            if (req_eof[w]) begin last = owner; owner = -1; end
         end else if (tracing) begin
            quiet++;
            if (quiet >= MI) begin last = owner; owner = -1; quiet = 0; m_pulse = 1'b1; end
         end
      end
      @(posedge clk);
      #1;
      if (timeout_pulse) pulse_cnt++;
      chk("valid_out", VW'(valid_out), VW'(m_valid));
      chk("busy", VW'(busy), VW'(owner >= 0));
      chk("timeout_pulse", VW'(timeout_pulse), VW'(m_pulse));
      chk("grant_id", VW'(grant_id), VW'(m_gid));
      if (m_valid) begin
         chk("eof_out", VW'(eof_out), VW'(m_eof));
         chk("chainId_out", VW'(chainId_out), VW'(m_chain));
         chk("vector_out", vector_out, m_vec);
      end
   endtask

   initial begin
      int seen_at;
      int pct;
      pulse_cnt = 0;
      rst_n = 1'b0; tracing = 1'b0; req_valid = '0; req_eof = '0; req_chainId = '0;
      pattern_vectors();
      step(); step();
      chk("reset_vector", vector_out, '0);

      // Two single-beat frames pending together: r0 then r2.
      rst_n = 1'b1; tracing = 1'b1; req_valid = 4'b0101; req_eof = 4'b1111; req_chainId = 4'b0100;
      step();
      chk("t1_r0_lane3", VW'(vector_out[3]), VW'(32'd3));
      step();
      chk("t1_r2_lane3", VW'(vector_out[3]), VW'(32'd203));
      req_valid = 4'b0000; step();

      // r0 single beat, then r1 3-beat frame with r3 pending throughout.
      req_valid = 4'b0001; req_eof = 4'b1111; step();
      req_valid = 4'b1010; req_eof = 4'b1000; step();
      chk("t2_r1_first", VW'(grant_id), VW'(2'd1));
      step();
      chk("t2_r3_stalled", VW'(req_ready[3]), VW'(1'b0));
      req_eof = 4'b1010; step();
      req_valid = 4'b1000; step();
      chk("t2_r3_after", VW'(grant_id), VW'(2'd3));
      req_valid = 4'b0000; step();

      // r2 opens a frame then goes silent with r0 pending: timeout 16 edges after the accept.
      req_valid = 4'b0100; req_eof = 4'b0000; step();
      req_valid = 4'b0001; req_eof = 4'b0001;
      seen_at = -1;
      for (int k = 1; k <= 17; k++) begin
         step();
         if (timeout_pulse && seen_at < 0) seen_at = k;
      end
      chk("t3_timeout_at", VW'(seen_at), VW'(16));
      chk("t3_r0_granted", VW'(grant_id), VW'(2'd0));
      chk("t3_r0_valid", VW'(valid_out), VW'(1'b1));
      req_valid = 4'b0000; step();

      // Tracing paused mid-frame for 30 cycles: frozen, no timeout.
      pulse_cnt = 0;
      req_valid = 4'b0010; req_eof = 4'b0000; step();
      tracing = 1'b0;
      for (int k = 0; k < 30; k++) begin
         req_valid = NR'($urandom);
         step();
      end
      chk("t4_no_pulse", VW'(pulse_cnt), VW'(0));
      chk("t4_busy", VW'(busy), VW'(1'b1));
      tracing = 1'b1; req_valid = 4'b0010; req_eof = 4'b0010; step();
      req_valid = 4'b0000; step();

      // r3 single beat sets the pointer, then everyone streams single-beat frames.
      req_valid = 4'b1000; req_eof = 4'b1111; step();
      req_valid = 4'b1111;
      for (int k = 0; k < 6; k++) begin
         step();
         chk("t5_order", VW'(grant_id), VW'(k % 4));
         chk("t5_valid", VW'(valid_out), VW'(1'b1));
      end
      req_valid = 4'b0000; step();

      // Reset during the second beat of a locked frame.
      req_valid = 4'b0001; req_eof = 4'b0000; step();
      rst_n = 1'b0; step();
      chk("t6_valid_cleared", VW'(valid_out), VW'(1'b0));
      chk("t6_busy_cleared", VW'(busy), VW'(1'b0));
      rst_n = 1'b1; req_valid = 4'b1111; req_eof = 4'b1111; step();
      chk("t6_r0_wins", VW'(grant_id), VW'(2'd0));

      // Randomized traffic in phases of differing valid density.
      for (int c = 0; c < 800; c++) begin
         case (c / 200)
            0:       pct = 70;
            1:       pct = 8;
            2:       pct = 95;
            default: pct = 40;
         endcase
         for (int r = 0; r < NR; r++) begin
            req_valid[r]   = ($urandom_range(99) < pct);
            req_eof[r]     = ($urandom_range(99) < 30);
            req_chainId[r] = 1'($urandom);
         end
         for (int j = 0; j < NR*N; j++) req_vector[j*DW +: DW] = $urandom();
         tracing = ($urandom_range(99) < 92);
         rst_n   = ($urandom_range(399) != 0);
         step();
      end
      rst_n = 1'b1; req_valid = '0; step(); step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/packer_frame_arbiter.md
Name: packer_frame_arbiter

Overview:
- Shares one dataPacker input port among NUM_REQ trace sources (one per monitored layer/stream).
- The packer keeps a single packed_data accumulator across chains, so frames from different sources must not interleave. The arbiter grants one requester round-robin and holds that grant until the requester's eof beat, or until an idle timeout releases it.
- Sits directly upstream of the packer and drives its valid_in, eof_in, chainId_in and vector_in.

Parameters:
- N, 8, vector lanes per beat; must match the packer's N.
- DATA_WIDTH, 32, bits per lane.
- NUM_REQ, 4, number of requesters; valid range 2..16.
- MAX_IDLE, 16, cycles a frame owner may stay non-valid before its lock is force-released; valid range 2..255.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  synchronous active-low reset.
- tracing  in  1  global trace enable; when low, no beat is accepted.
- req_valid  in  NUM_REQ  per-requester beat valid.
- req_eof  in  NUM_REQ  per-requester end-of-frame, qualified by req_valid.
- req_chainId  in  NUM_REQ  per-requester chain id (1 bit each).
- req_vector  in  NUM_REQ*N*DATA_WIDTH  flattened; requester r, lane i at bits [(r*N+i)*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  NUM_REQ  per-requester accept; combinational.
- valid_out  out  1  registered beat valid to the packer.
- eof_out  out  1  registered eof of the forwarded beat.
- chainId_out  out  1  registered chain id.
- vector_out  out  [DATA_WIDTH-1:0] x [N-1:0]  registered forwarded vector.
- grant_id  out  $clog2(NUM_REQ)  current or most recent owner index.
- busy  out  1  high while in LOCKED.
- timeout_pulse  out  1  one-cycle pulse when a lock is force-released.

Behaviour:
- Beat transfer: a beat is accepted when req_valid[r] && req_ready[r]. It is forwarded on the outputs the next cycle; latency 1. No beat is ever dropped or duplicated. valid_out is high only in the cycle after an accepted beat.
- req_ready: at most one bit is high, and only when tracing=1. It may depend combinationally on req_valid and the state; it never depends on any output of the packer.
- Reset (rst_n=0 at posedge):
  - state=IDLE; rr_ptr=NUM_REQ-1, so requester 0 has top priority first.
  - idle_cnt=0; grant_id=0.
  - valid_out, eof_out, chainId_out, busy, timeout_pulse = 0; vector_out = all zeros.
  - Reset mid-frame discards the lock. Any beat in flight is not forwarded.
- IDLE:
  - Winner w is the first r with req_valid[r]=1, searching from rr_ptr+1 upward with wrap modulo NUM_REQ.
  - req_ready[w]=1 and the beat is accepted this cycle; grant_id<=w.
  - If req_eof[w]=1 (single-beat frame): stay IDLE, rr_ptr<=w.
  - Otherwise: go to LOCKED with owner=w, idle_cnt<=0.
  - With no req_valid, or tracing=0: nothing is accepted and the state is held.
- LOCKED:
  - Only req_ready[owner] can be high; all other requesters are stalled regardless of their valid.
  - Accepted beat with eof=1: go to IDLE, rr_ptr<=owner, idle_cnt<=0.
  - Accepted beat with eof=0: stay LOCKED, idle_cnt<=0.
  - Owner not valid while tracing=1: idle_cnt increments. When idle_cnt reaches MAX_IDLE-1 with no accept, go to IDLE next cycle, rr_ptr<=owner, timeout_pulse=1 for one cycle, and nothing is forwarded.
  - tracing=0: state and idle_cnt are frozen, and no timeout can occur.
- Simultaneous events:
  - eof accept in the same cycle as the timeout threshold: the beat is accepted and released normally, with no timeout_pulse.
  - Release and a new grant never occur in the same cycle; the earliest new grant is the cycle after release.
- grant_id holds its value between frames. busy equals (state==LOCKED).
- idle_cnt is 8 bits wide and saturates; it cannot wrap.

Test Plan:
- Reset, then req_valid=4'b0101, both with eof=1 and vector lanes = r*100+i, held for 2 cycles -> requester 0 forwarded (vector_out[3]=3) then requester 2 (vector_out[3]=203); grant_id 0 then 2; valid_out high 2 cycles starting 1 cycle after each accept.
- Requester 1 sends a 3-beat frame (eof on beat 3) while requester 3 is valid throughout -> req_ready[3]=0 for 3 cycles; output order is r1,r1,r1,r3; busy high for exactly 2 cycles.
- Requester 2 sends 1 non-eof beat then drops valid; MAX_IDLE=16 -> timeout_pulse high for 1 cycle, exactly 16 cycles after the accept; requester 0, pending throughout, is granted next.
- Mid-frame, tracing=0 for 30 cycles -> no accepts, no timeout_pulse, busy stays 1; frame completes normally after tracing returns to 1.
- All 4 requesters continuously valid with single-beat frames -> grant order 0,1,2,3,0,1 with one beat per cycle; valid_out continuously high.
- rst_n=0 in the second beat of a locked frame -> next cycle valid_out=0 and busy=0; rr_ptr is reset, so requester 0 wins the next arbitration.
